// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the downstream Gray-to-binary decode stage.
// Functions operate on a MAX_WIDTH word; callers zero-extend narrower values and truncate the result.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Zero-extension is harmless: the top Gray bit equals the top binary bit either way.
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and result bundle of the Gray counter; master drives the controls, slave is the counter.
interface gray_counter_if #(
  parameter int WIDTH = gray_pkg::DEFAULT_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  gray, bin, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output gray, bin, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down Gray counter with synchronous load; drives Gray word, binary twin and a wrap pulse.
// Latency: one cycle from sampling edge to bin/gray/wrap; all outputs registered.
// Backpressure: none; the counter acts on its controls every cycle.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  gray_counter_if.slave cnt
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_counter: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  // gray is registered from next_bin rather than decoded from bin, so both land on the same edge.
  always_comb begin
    next_bin  = cnt.bin;
    next_wrap = 1'b0;
    if (cnt.load) begin
      next_bin = cnt.load_val;
    end else if (cnt.en) begin
      if (cnt.up) begin
        next_bin  = cnt.bin + ONE;
        next_wrap = (cnt.bin == ALL_ONES);
      end else begin
        next_bin  = cnt.bin - ONE;
        next_wrap = (cnt.bin == '0);
      end
    end
    next_gray = WIDTH'(bin2gray(word_t'(next_bin)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt.bin  <= '0;
      cnt.gray <= '0;
      cnt.wrap <= 1'b0;
    end else begin
      cnt.bin  <= next_bin;
      cnt.gray <= next_gray;
      cnt.wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: stimulus pushes model expectations, a monitor pops and compares.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst;

  gray_counter_if #(.WIDTH(W)) cnt_if ();

  gray_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .cnt (cnt_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int gray;
    bit wrap;
    bit en_step;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model    = 0;
  int   walk[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model counts as an integer modulo 2^W.
  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input int gray_ovr = -1);
    exp_t x;
    @(negedge clk);
    rst             = r;
    cnt_if.en       = e;
    cnt_if.up       = u;
    cnt_if.load     = l;
    cnt_if.load_val = lv[W-1:0];
    x.wrap    = 1'b0;
    x.en_step = 1'b0;
    if (r) begin
      model = 0;
    end else if (l) begin
      model = lv % MOD;
    end else if (e) begin
      x.en_step = 1'b1;
      if (u) begin
        x.wrap = (model == MOD - 1);
        model  = (model + 1) % MOD;
      end else begin
        x.wrap = (model == 0);
        model  = (model + MOD - 1) % MOD;
      end
    end
    x.bin  = model;
    x.gray = (gray_ovr >= 0) ? gray_ovr : (model ^ (model >> 1));
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    logic [W-1:0] prev_gray;
    exp_t x;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("bin", int'(cnt_if.bin), x.bin);
        check("gray", int'(cnt_if.gray), x.gray);
        check("wrap", int'(cnt_if.wrap), int'(x.wrap));
        check("gray_vs_bin2gray", int'(cnt_if.gray), int'(bin2gray(word_t'(cnt_if.bin))));
        check("gray2bin_vs_bin", int'(gray2bin(word_t'(cnt_if.gray))), int'(cnt_if.bin));
        if (x.en_step) check("gray_hamming", $countones(prev_gray ^ cnt_if.gray), 1);
        prev_gray = cnt_if.gray;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    bit r, e, u, l;
    rst             = 1'b1;
    cnt_if.en       = 1'b0;
    cnt_if.up       = 1'b0;
    cnt_if.load     = 1'b0;
    cnt_if.load_val = '0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 5);

    // Full up walk against the literal Gray sequence, including the wrap back to 0000.
    for (int k = 1; k <= 16; k++) step(0, 1, 1, 0, 0, walk[k % 16]);

    // Down from zero wraps to all-ones, then hold.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Load wins over en.
    step(0, 1, 1, 1, 10);
    step(0, 0, 1, 0, 3);

    // Reset mid-count wins over en, count resumes from zero.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);

    // Back-to-back wraps with alternating direction at the boundary.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < W; k++) step(0, 1, k[0], 0, 0);

    // Load all-ones then step up across the boundary.
    step(0, 0, 0, 1, MOD - 1);
    step(0, 1, 1, 0, 0);

    for (int k = 0; k < 1000; k++) begin
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) != 0;
      step(r, e, u, l, int'($urandom_range(0, MOD - 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
